// File: rtl/proc_io_pkg.sv
// Shared types and constants for the processor I/O bring-up harness.
package proc_io_pkg;

  // Core sequencing states: reset hold, start delay, running.
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_e;

  // Width of the interrupt delay counter (matches the irq_delay port).
  localparam int unsigned IRQ_CNT_W = 8;

  // Larger of two unsigned values, used for counter sizing.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a zero-when-empty head output and a synchronous flush.
// Ports: clk/rst (async active-low), flush, push/din, pop/dout, full, empty.
// A pop makes room for a push in the same cycle, so push+pop while full keeps
// the count. A pop while empty is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push_c, do_pop_c;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign dout  = empty ? '0 : mem_q[rd_q];

  // Pointer/count update; pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    do_pop_c  = pop & ~empty;
    do_push_c = push & (~full | do_pop_c);
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop_c)  rd_d = rd_q + AW'(1);
      if (do_push_c) wr_d = wr_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push_c && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/proc_io_harness.sv
// Bring-up harness around the processor core's control and I/O pins.
// Ports: clk, rst (async active-low), restart; core_rst/core_start/running
// sequencing; in_push/in_data/in_full/in_empty/in_ack/core_in stimulus FIFO;
// core_out/log_pop/log_data/log_valid/log_overflow output-change log;
// irq_req/irq_delay/irq_busy/core_irq delayed interrupt pulse.
module proc_io_harness
  import proc_io_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned START_DELAY = 0,
  parameter int unsigned IN_DEPTH    = 8,
  parameter int unsigned LOG_DEPTH   = 8,
  parameter int unsigned INT_PULSE   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  output logic                 core_rst,
  output logic                 core_start,
  output logic                 running,
  input  logic                 in_push,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_full,
  output logic                 in_empty,
  input  logic                 in_ack,
  output logic [DATA_W-1:0]    core_in,
  input  logic [DATA_W-1:0]    core_out,
  input  logic                 log_pop,
  output logic [DATA_W-1:0]    log_data,
  output logic                 log_valid,
  output logic                 log_overflow,
  input  logic                 irq_req,
  input  logic [IRQ_CNT_W-1:0] irq_delay,
  output logic                 irq_busy,
  output logic                 core_irq
);

  localparam int unsigned CNT_MAX  = max_u(RST_CYCLES, START_DELAY);
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned RST_LOAD = RST_CYCLES - 1;
  localparam int unsigned SD_LOAD  = (START_DELAY > 0) ? START_DELAY - 1 : 0;
  localparam int unsigned PULSE_W  = $clog2(INT_PULSE + 1);

  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     seq_cnt_q, seq_cnt_d;
  logic                 core_rst_q, core_rst_d;
  logic                 run_q, run_d;
  logic                 armed_q, armed_d;
  logic [DATA_W-1:0]    prev_q, prev_d;
  logic                 log_ovf_q, log_ovf_d;
  logic                 irq_busy_q, irq_busy_d;
  logic                 core_irq_q, core_irq_d;
  logic [IRQ_CNT_W-1:0] irq_cnt_q, irq_cnt_d;
  logic [PULSE_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic                 log_push_c, log_full, log_empty;

  assign core_rst     = core_rst_q;
  assign core_start   = run_q;
  assign running      = run_q;
  assign log_valid    = ~log_empty;
  assign log_overflow = log_ovf_q;
  assign irq_busy     = irq_busy_q;
  assign core_irq     = core_irq_q;

  // Stimulus buffer: never flushed, active in every state.
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (in_push),
    .pop   (in_ack),
    .din   (in_data),
    .dout  (core_in),
    .full  (in_full),
    .empty (in_empty)
  );

  // Output-change log: cleared on restart.
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(LOG_DEPTH)) u_log_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (restart),
    .push  (log_push_c),
    .pop   (log_pop),
    .din   (core_out),
    .dout  (log_data),
    .full  (log_full),
    .empty (log_empty)
  );

  // Reset/start sequencer; WAIT is skipped entirely when START_DELAY is 0.
  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    if (restart) begin
      state_d   = ST_HOLD;
      seq_cnt_d = CNT_W'(RST_LOAD);
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (seq_cnt_q == '0) begin
            if (START_DELAY == 0) begin
              state_d = ST_RUN;
            end else begin
              state_d   = ST_WAIT;
              seq_cnt_d = CNT_W'(SD_LOAD);
            end
          end else begin
            seq_cnt_d = seq_cnt_q - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (seq_cnt_q == '0) state_d = ST_RUN;
          else                 seq_cnt_d = seq_cnt_q - CNT_W'(1);
        end
        ST_RUN:  state_d = ST_RUN;
        default: begin
          state_d   = ST_HOLD;
          seq_cnt_d = CNT_W'(RST_LOAD);
        end
      endcase
    end
    core_rst_d = (state_d == ST_HOLD);
    run_d      = (state_d == ST_RUN);
  end

  // Output monitor: first RUN cycle only primes prev, later changes are logged.
  always_comb begin
    armed_d    = armed_q;
    prev_d     = prev_q;
    log_ovf_d  = log_ovf_q;
    log_push_c = 1'b0;
    if (restart) begin
      armed_d   = 1'b0;
      log_ovf_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (!armed_q) begin
        armed_d = 1'b1;
        prev_d  = core_out;
      end else if (core_out != prev_q) begin
        prev_d     = core_out;
        log_push_c = 1'b1;
        if (log_full && !log_pop) log_ovf_d = 1'b1;
      end
    end else begin
      armed_d = 1'b0;
    end
  end

  // Interrupt: count down irq_delay, then hold core_irq for INT_PULSE cycles.
  always_comb begin
    irq_busy_d  = irq_busy_q;
    core_irq_d  = core_irq_q;
    irq_cnt_d   = irq_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    if (restart) begin
      irq_busy_d = 1'b0;
      core_irq_d = 1'b0;
      irq_cnt_d  = '0;
    end else if (irq_busy_q) begin
      if (core_irq_q) begin
        if (pulse_cnt_q == '0) begin
          core_irq_d = 1'b0;
          irq_busy_d = 1'b0;
        end else begin
          pulse_cnt_d = pulse_cnt_q - PULSE_W'(1);
        end
      end else if (irq_cnt_q == '0) begin
        core_irq_d  = 1'b1;
        pulse_cnt_d = PULSE_W'(INT_PULSE - 1);
      end else begin
        irq_cnt_d = irq_cnt_q - IRQ_CNT_W'(1);
      end
    end else if ((state_q == ST_RUN) && irq_req) begin
      irq_busy_d = 1'b1;
      irq_cnt_d  = irq_delay;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HOLD;
      seq_cnt_q   <= CNT_W'(RST_LOAD);
      core_rst_q  <= 1'b1;
      run_q       <= 1'b0;
      armed_q     <= 1'b0;
      prev_q      <= '0;
      log_ovf_q   <= 1'b0;
      irq_busy_q  <= 1'b0;
      core_irq_q  <= 1'b0;
      irq_cnt_q   <= '0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      seq_cnt_q   <= seq_cnt_d;
      core_rst_q  <= core_rst_d;
      run_q       <= run_d;
      armed_q     <= armed_d;
      prev_q      <= prev_d;
      log_ovf_q   <= log_ovf_d;
      irq_busy_q  <= irq_busy_d;
      core_irq_q  <= core_irq_d;
      irq_cnt_q   <= irq_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

endmodule

// File: doc/proc_io_harness.md
Name: proc_io_harness

Overview:
- Synthesisable bring-up harness that wraps the processor core's control and I/O pins.
- Sequences the core's reset and start: a parametrised reset hold, then a start delay, then run.
- Buffers input-port stimulus in a FIFO and logs output-port value changes into a second FIFO.
- Injects interrupts after a programmable delay. Sits between a host/debug controller and the core's clk/rst/start/inputPort/outputPort/interrupt pins.

Parameters:
- DATA_W, 16, width of the core input/output ports.
- RST_CYCLES, 2, cycles core_rst is held high after harness reset release or restart (≥1).
- START_DELAY, 0, cycles between core_rst falling and core_start rising.
- IN_DEPTH, 8, input stimulus FIFO depth (power of 2).
- LOG_DEPTH, 8, output log FIFO depth (power of 2).
- INT_PULSE, 1, core_irq high time in cycles (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- restart  in  1  synchronous re-sequence request.
- core_rst  out  1  active-high reset to core.
- core_start  out  1  start level to core.
- running  out  1  high in RUN state.
- in_push  in  1  push in_data into the stimulus FIFO.
- in_data  in  DATA_W  stimulus word.
- in_full  out  1  stimulus FIFO full.
- in_empty  out  1  stimulus FIFO empty.
- in_ack  in  1  core consumed core_in; pop the stimulus FIFO.
- core_in  out  DATA_W  drives the core inputPort.
- core_out  in  DATA_W  core outputPort.
- log_pop  in  1  pop the log FIFO.
- log_data  out  DATA_W  log FIFO head.
- log_valid  out  1  log FIFO non-empty.
- log_overflow  out  1  sticky: a change was dropped.
- irq_req  in  1  interrupt request.
- irq_delay  in  8  cycles before assertion.
- irq_busy  out  1  interrupt in progress.
- core_irq  out  1  drives the core interrupt.

Behaviour:
- Reset (rst=0, asynchronous) outputs: core_rst=1, core_start=0, running=0, core_in=0, in_empty=1, in_full=0, log_data=0, log_valid=0, log_overflow=0, irq_busy=0, core_irq=0. Both FIFOs are emptied; FSM enters HOLD with its counter loaded.
- FSM HOLD: core_rst=1, core_start=0. After exactly RST_CYCLES clock edges, go to WAIT.
- FSM WAIT: core_rst=0, core_start=0. After START_DELAY cycles, go to RUN. With START_DELAY=0, WAIT lasts zero cycles and HOLD goes directly to RUN.
- FSM RUN: core_rst=0, core_start=1 held, running=1.
- restart=1 in any state: next state HOLD with counter reloaded. Log FIFO flushed, log_overflow cleared, interrupt cancelled (irq_busy=0, core_irq=0). Stimulus FIFO contents retained. restart has priority over all other same-cycle events.
- Stimulus FIFO:
  - core_in = head word when non-empty, 0 when empty (combinational from registered storage).
  - Push when full: ignored. in_ack when empty: ignored.
  - Push and ack in the same cycle: both take effect, including when full or empty (empty+push+ack: only the push takes effect).
  - Pointers wrap modulo IN_DEPTH.
  - Active in all states.
- Output monitor, RUN only:
  - On the first RUN cycle, capture core_out into a prev register; nothing is logged.
  - On each later cycle, if core_out != prev, push core_out into the log and update prev.
  - Log full with no pop in that cycle: drop the word and set log_overflow.
  - Log full with a pop in that cycle: push accepted, no overflow.
  - log_pop when empty: ignored.
- Interrupt:
  - irq_req is accepted only in RUN with irq_busy=0; otherwise ignored (no queuing).
  - Accept at edge t: irq_busy=1 and counter=irq_delay. core_irq is high on cycles t+1+irq_delay through t+irq_delay+INT_PULSE.
  - irq_busy clears together with core_irq falling.
  - irq_delay=0 gives assertion on the next cycle.
- Widths:
  - FIFO occupancy counters are clog2(depth)+1 bits.
  - The reset/start counter is sized for max(RST_CYCLES, START_DELAY) and saturates.

Decomposition:
- Package proc_io_pkg: FSM state enum (HOLD, WAIT, RUN) and the interrupt counter width constant (8).
- One sub-module, sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty, flush), instantiated twice: stimulus FIFO and log FIFO.

Test Plan:
- Sequencing: release rst at cycle 0 with defaults -> core_rst=1 on cycles 0–1, 0 from cycle 2; core_start=1 and running=1 from cycle 2 (START_DELAY=0). Repeat with START_DELAY=3 -> core_start rises at cycle 5.
- Stimulus FIFO: push 0x0001..0x0008 (fills, in_full=1), push 0x0009 -> ignored. Eight acks return 0x0001..0x0008 on core_in, then core_in=0 and in_empty=1. Push+ack in the same cycle while full -> count unchanged.
- Output log: in RUN drive core_out 0x0000 -> 0x00AA -> 0x00AA -> 0x0055 -> log holds {0x00AA, 0x0055}. Ten further distinct changes without pops -> 8 entries held, log_overflow=1. restart -> log_valid=0, log_overflow=0.
- Interrupt: irq_req with irq_delay=4 at edge t -> core_irq high only on cycle t+5. A second irq_req at t+2 -> ignored. irq_req during HOLD -> ignored.
- Mid-operation: restart during an interrupt delay and with 3 stimulus words queued -> core_irq never asserts, core_rst=1 for 2 cycles, 3 words still present. Asynchronous rst=0 mid-RUN -> all outputs take reset values immediately without a clock edge.
